fft_bitrev_reorder: RTL and testbench

Output reorder buffer for the N-point pipelined FFT. The FFT core's delay-line stages emit each frame in bit-reversed index order. This block writes each frame into a ping-pong memory at bit-reversed addresses and reads it back in natural order. The result is a streaming valid/ready output with frame markers. It sits between the last butterfly/delay stage and the downstream consumer.

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_pingpong_ram.sv | 29 ++
 rtl/fft_bitrev_reorder.sv | 134 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, complex sample type and bit-reversal helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fft_pkg;

  localparam int FFT_N    = 128;
  localparam int FFT_LOGN = 7;
  localparam int SAMPLE_W = 32;

  // Widest index the bit-reversal helper handles, and the width of a bit index into it.
  localparam int BR_MAX_W = 16;
  localparam int BR_IDX_W = 4;

  typedef struct packed {
    logic [SAMPLE_W/2-1:0] re;
    logic [SAMPLE_W/2-1:0] im;
  } cplx_t;

  // Reverse the low 'logn' bits of x; bits at and above logn come back as zero.
  function automatic logic [BR_MAX_W-1:0] bitrev(input logic [BR_MAX_W-1:0] x,
                                                 input int unsigned logn);
    logic [BR_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BR_MAX_W; i++) begin
      if (i < logn) begin
        r[BR_IDX_W'(i)] = x[BR_IDX_W'(logn - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store addressed as {bank, idx}: registered write, asynchronous read.
// Latency: a write is visible to the read port the cycle after it is issued.
// Backpressure: none; the caller owns bank arbitration.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int AW = FFT_LOGN + 1,
  parameter int DW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem_q [2**AW];

  // Port A: one word written per cycle when enabled; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order through a ping-pong buffer.
// Latency: first sample of a frame is presented one cycle after its last input is accepted.
// Backpressure: out_ready stalls reads only; in_ready drops once both banks hold unread frames.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N    = FFT_N,
  parameter int LOGN = FFT_LOGN,
  parameter int DW   = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  input  logic          out_ready
);

  localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);

  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [LOGN-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]      full_q, full_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;

  logic            wr_fire;
  logic            load;
  logic [LOGN-1:0] wr_idx;
  logic [DW-1:0]   rd_dat;

  assign in_ready = !full_q[wr_bank_q];

  // Samples arrive in bit-reversed order, so writing at bitrev(count) leaves the bank in natural order.
  always_comb begin
    wr_idx = LOGN'(bitrev(BR_MAX_W'(wr_cnt_q), LOGN));
  end

  fft_pingpong_ram #(
    .AW (LOGN + 1),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank_q, wr_idx}),
    .wr_dat  (in_data),
    .rd_addr ({rd_bank_q, rd_cnt_q}),
    .rd_dat  (rd_dat)
  );

  // Write-side bank filling and read-side output register; set and clear never hit the same bank.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    wr_fire = in_valid && in_ready;
    load    = full_q[rd_bank_q] && (!out_valid_q || out_ready);

    if (wr_fire) begin
      if (wr_cnt_q == CNT_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + LOGN'(1);
      end
    end

    if (load) begin
      out_data_d  = rd_dat;
      out_valid_d = 1'b1;
      out_sop_d   = (rd_cnt_q == '0);
      out_eop_d   = (rd_cnt_q == CNT_LAST);
      if (rd_cnt_q == CNT_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + LOGN'(1);
      end
    end else if (out_ready) begin
      // Consumer took the sample and nothing is ready behind it: go idle, keep the data bits.
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end
  end

  // State register; reset discards any partial or unread frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      full_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the FFT bit-reversal reorder buffer.
// Drives inputs #1 after each rising edge and samples outputs at the same point.
// Output transfers are captured into queues and compared against bench-computed frames.
module tb_fft_bitrev_reorder;

  localparam int N    = 128;
  localparam int LOGN = 7;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_dat [$];
  logic        got_sop [$];
  logic        got_eop [$];

  fft_bitrev_reorder #(
    .N    (N),
    .LOGN (LOGN),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] br7(input int x);
    logic [6:0] v;
    logic [6:0] r;
    v = 7'(x);
    for (int i = 0; i < 7; i++) r[i] = v[6-i];
    return {25'd0, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    got_dat.delete();
    got_sop.delete();
    got_eop.delete();
  endtask

  // Record an output transfer happening at the coming edge, then advance one cycle.
  task automatic tick();
    if (out_valid && out_ready) begin
      got_dat.push_back(out_data);
      got_sop.push_back(out_sop);
      got_eop.push_back(out_eop);
    end
    @(posedge clk);
    #1;
  endtask

  // Feed n_in samples (frame f, index k -> base + f*stride + k) and run until n_out outputs are captured.
  task automatic run(input int n_in, input logic [31:0] base, input logic [31:0] stride,
                     input int vld_pct, input int rdy_pct, input int n_out, input int budget,
                     output int sent, output int rdy_low, output int gaps);
    logic acc;
    logic seen;
    sent    = 0;
    rdy_low = 0;
    gaps    = 0;
    seen    = 1'b0;
    for (int c = 0; c < budget && (sent < n_in || got_dat.size() < n_out); c++) begin
      if (sent < n_in) begin
        in_valid = ($urandom_range(0, 99) < vld_pct);
        in_data  = base + (sent / N) * stride + (sent % N);
        if (!in_ready) rdy_low++;
      end else begin
        in_valid = 1'b0;
      end
      if (rdy_pct >= 100)     out_ready = 1'b1;
      else if (rdy_pct <= 0)  out_ready = 1'b0;
      else                    out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (out_valid) seen = 1'b1;
      else if (seen) gaps++;
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
  endtask

  // Compare captured outputs against whole frames in natural order with sop/eop markers.
  task automatic check_frames(input string tag, input int n, input logic [31:0] base,
                              input logic [31:0] stride);
    int bad;
    logic [31:0] exp;
    bad = 0;
    check({tag, "_count"}, got_dat.size(), n);
    for (int i = 0; i < n && i < got_dat.size(); i++) begin
      exp = base + (i / N) * stride + br7(i % N);
      if (got_dat[i] !== exp || got_sop[i] !== (i % N == 0) || got_eop[i] !== (i % N == N - 1))
        bad++;
    end
    check({tag, "_order_bad"}, bad, 0);
  endtask

  initial begin
    int sent;
    int rl;
    int gp;
    int acc3;

    // Reset state
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Single frame, in_data = k, consumer always ready
    clear_q();
    run(N, 32'h0, 32'd128, 100, 100, 0, 400, sent, rl, gp);
    check("b_sent", sent, N);
    check("b_lat_idle", out_valid, 0);
    tick();
    check("b_first_valid", out_valid, 1);
    check("b_first_sop", out_sop, 1);
    check("b_first_data", out_data, 0);
    run(0, 32'h0, 32'd128, 100, 100, N, 400, sent, rl, gp);
    check_frames("b", N, 32'h0, 32'd128);
    check("b_idx1", got_dat[1], 64);
    check("b_idx2", got_dat[2], 32);
    check("b_idx3", got_dat[3], 96);
    check("b_idx4", got_dat[4], 16);
    check("b_idx127", got_dat[127], 127);
    check("b_idle_after", out_valid, 0);

    // Four back-to-back frames, continuous valid/ready
    clear_q();
    run(4 * N, 32'h0, 32'd128, 100, 100, 4 * N, 3000, sent, rl, gp);
    check("c_sent", sent, 4 * N);
    check("c_in_ready_low", rl, 0);
    check("c_out_gaps", gp, 0);
    check_frames("c", 4 * N, 32'h0, 32'd128);

    // Consumer stalled: two frames fill both banks, third is refused, output held
    clear_q();
    run(2 * N, 32'h1000, 32'h1000, 100, 0, 0, 1000, sent, rl, gp);
    check("d_sent", sent, 2 * N);
    check("d_in_ready", in_ready, 0);
    check("d_hold_valid", out_valid, 1);
    check("d_hold_sop", out_sop, 1);
    check("d_hold_data", out_data, 32'h1000);
    acc3 = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h3000 + i;
      if (in_ready) acc3++;
      tick();
    end
    in_valid = 1'b0;
    check("d_f3_accepted", acc3, 0);
    check("d_hold_valid2", out_valid, 1);
    check("d_hold_sop2", out_sop, 1);
    check("d_hold_data2", out_data, 32'h1000);
    run(0, 32'h0, 32'h0, 100, 100, 2 * N, 1000, sent, rl, gp);
    check_frames("d", 2 * N, 32'h1000, 32'h1000);
    for (int i = 0; i < 5; i++) tick();
    check("d_no_extra", got_dat.size(), 2 * N);
    check("d_in_ready_after", in_ready, 1);
    check("d_idle_after", out_valid, 0);

    // Random input gaps and 50% output ready over ten frames
    clear_q();
    run(10 * N, 32'h10000, 32'd128, 70, 50, 10 * N, 20000, sent, rl, gp);
    check("e_sent", sent, 10 * N);
    check_frames("e", 10 * N, 32'h10000, 32'd128);

    // Reset with one unread frame and 60 samples of the next
    clear_q();
    run(N + 60, 32'h5000, 32'h1000, 100, 0, 0, 1000, sent, rl, gp);
    check("f_sent", sent, N + 60);
    check("f_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("f_post_valid", out_valid, 0);
    check("f_post_in_ready", in_ready, 1);
    check("f_post_sop", out_sop, 0);
    clear_q();
    run(N, 32'h9000, 32'h1000, 100, 100, N, 600, sent, rl, gp);
    check_frames("f", N, 32'h9000, 32'h1000);
    for (int i = 0; i < 10; i++) tick();
    check("f_no_extra", got_dat.size(), N);

    // Last write of frame 2 lands on the same edge as frame 1's eop load
    clear_q();
    run(2 * N, 32'h7000, 32'h1000, 100, 100, N - 1, 1000, sent, rl, gp);
    check("g_sent", sent, 2 * N);
    check("g_eop_valid", out_valid, 1);
    check("g_eop", out_eop, 1);
    check("g_eop_data", out_data, 32'h707F);
    check("g_in_ready", in_ready, 1);
    tick();
    check("g_next_valid", out_valid, 1);
    check("g_next_sop", out_sop, 1);
    check("g_next_data", out_data, 32'h8000);
    run(0, 32'h0, 32'h0, 100, 100, 2 * N, 1000, sent, rl, gp);
    check_frames("g", 2 * N, 32'h7000, 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
